joy_db15_tx: RTL and testbench

JOY_DB15_TX -- requirements
Module: joy_db15_tx

---
 rtl/joy_db15_tx.sv | 141 ++++++++++++++
 tb/tb_joy_db15_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/joy_db15_tx.sv
// DB15 joystick serial transmitter.
// Two 16-bit button words are presented to a host as a 32-bit active-low
// serial stream, clocked by the host's JOY_CLK/JOY_LOAD pair.
module joy_db15_tx #(
  parameter int TIMEOUT    = 48000,
  parameter int FRAME_BITS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  input  logic        JOY_CLK,
  input  logic        JOY_LOAD,
  output logic        JOY_DATA,
  output logic        frame_done,
  output logic        overrun,
  output logic        link_active,
  output logic [5:0]  bit_cnt
);

  localparam int              TW          = $clog2(TIMEOUT + 1);
  localparam logic [5:0]      FRAME_CNT   = 6'(FRAME_BITS);
  localparam logic [TW-1:0]   TIMEOUT_CNT = TW'(TIMEOUT);

  // Frame state: IDLE until a load has armed the shift register, so that
  // stray host clocks after reset cannot advance bit_cnt.
  typedef enum logic {
    ST_IDLE,
    ST_ARMED
  } frameState_e;

  logic        clkMeta_q, clkSync_q, clkPrev_q;
  logic        loadMeta_q, loadSync_q, loadPrev_q;
  logic        clkRise, loadActive, loadFall;

  frameState_e state_q;
  logic [31:0] shift_q;
  logic [5:0]  bitCnt_q;
  logic        overrun_q;
  logic        frameDone_q;
  logic        data_q;

  logic [TW-1:0] timeout_q, timeout_d;

  // Two-flop synchronizers plus an edge-detect stage for both host inputs;
  // idle level of both lines is high, so everything resets to 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clkMeta_q  <= 1'b1;
      clkSync_q  <= 1'b1;
      clkPrev_q  <= 1'b1;
      loadMeta_q <= 1'b1;
      loadSync_q <= 1'b1;
      loadPrev_q <= 1'b1;
    end else begin
      clkMeta_q  <= JOY_CLK;
      clkSync_q  <= clkMeta_q;
      clkPrev_q  <= clkSync_q;
      loadMeta_q <= JOY_LOAD;
      loadSync_q <= loadMeta_q;
      loadPrev_q <= loadSync_q;
    end
  end

  assign clkRise    = clkSync_q & ~clkPrev_q;
  assign loadActive = ~loadSync_q;
  assign loadFall   = ~loadSync_q & loadPrev_q;

  // Frame FSM: load has priority over shifting; a shift past the last bit
  // only flags overrun, leaving the (already empty) register untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bitCnt_q    <= '0;
      overrun_q   <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      if (loadActive) begin
        state_q   <= ST_ARMED;
        shift_q   <= {joystick2, joystick1};
        bitCnt_q  <= '0;
        overrun_q <= 1'b0;
      end else if (clkRise) begin
        case (state_q)
          ST_ARMED: begin
            if (bitCnt_q == FRAME_CNT) begin
              overrun_q <= 1'b1;
            end else begin
              shift_q  <= {1'b0, shift_q[31:1]};
              bitCnt_q <= bitCnt_q + 6'd1;
              if (bitCnt_q == FRAME_CNT - 6'd1) begin
                frameDone_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Output register: line is active-low, so an empty register reads released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= 1'b1;
    end else begin
      data_q <= ~shift_q[0];
    end
  end

  // Link watchdog next state: restart on each load strobe, otherwise count up
  // and hold at TIMEOUT.
  always_comb begin
    timeout_d = timeout_q;
    if (loadFall) begin
      timeout_d = '0;
    end else if (timeout_q < TIMEOUT_CNT) begin
      timeout_d = timeout_q + TW'(1);
    end
  end

  // Link watchdog register; starts expired so the link reads inactive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_q <= TIMEOUT_CNT;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign JOY_DATA    = data_q;
  assign frame_done  = frameDone_q;
  assign overrun     = overrun_q;
  assign bit_cnt     = bitCnt_q;
  assign link_active = (timeout_q < TIMEOUT_CNT);

endmodule

// File: tb/tb_joy_db15_tx.sv
// Scoreboard bench for joy_db15_tx: the stimulus process queues expected
// line states, a negedge monitor pops and compares them when they fall due.
module tb_joy_db15_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] joystick1, joystick2;
  logic        JOY_CLK, JOY_LOAD;
  logic        JOY_DATA, frame_done, overrun, link_active;
  logic [5:0]  bit_cnt;

  joy_db15_tx dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .joystick1   (joystick1),
    .joystick2   (joystick2),
    .JOY_CLK     (JOY_CLK),
    .JOY_LOAD    (JOY_LOAD),
    .JOY_DATA    (JOY_DATA),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .link_active (link_active),
    .bit_cnt     (bit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         due;
    bit         dataOnly;
    logic       expData;
    logic [5:0] expCnt;
    logic       expOvr;
    int         expFd;
    logic       expLink;
  } expect_t;

  expect_t sbQ[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fdSeen = 0;
  bit linkWatch = 0;
  bit linkDrop = 0;

  // Reference model of the host-visible frame state.
  logic [31:0] mFrame;
  int          mShifts;
  bit          mArmed;
  logic        mOvr;
  int          fdTotal = 0;
  logic        mLink;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: count frame_done pulses, then retire any expectations now due.
  always @(negedge clk) begin
    expect_t it;
    if (frame_done === 1'b1) fdSeen++;
    if (linkWatch && link_active !== 1'b1) linkDrop = 1'b1;
    while (sbQ.size() != 0 && sbQ[0].due <= cyc) begin
      it = sbQ.pop_front();
      checkOutput({it.name, ".data"}, 32'(JOY_DATA), 32'(it.expData));
      if (!it.dataOnly) begin
        checkOutput({it.name, ".cnt"},  32'(bit_cnt),     32'(it.expCnt));
        checkOutput({it.name, ".ovr"},  32'(overrun),     32'(it.expOvr));
        checkOutput({it.name, ".fd"},   32'(fdSeen),      32'(it.expFd));
        checkOutput({it.name, ".link"}, 32'(link_active), 32'(it.expLink));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic loadLvl, input logic clkLvl);
    @(negedge clk);
    JOY_LOAD = loadLvl;
    JOY_CLK  = clkLvl;
  endtask

  task automatic pushExpect(input string name, input int due, input bit dataOnly);
    expect_t it;
    it.name     = name;
    it.due      = due;
    it.dataOnly = dataOnly;
    it.expData  = (mShifts < 32) ? ~mFrame[mShifts] : 1'b1;
    it.expCnt   = 6'(mShifts);
    it.expOvr   = mOvr;
    it.expFd    = fdTotal;
    it.expLink  = mLink;
    sbQ.push_back(it);
  endtask

  task automatic modelReset();
    mFrame  = '0;
    mShifts = 0;
    mArmed  = 0;
    mOvr    = 1'b0;
    mLink   = 1'b0;
  endtask

  task automatic modelLoad(input logic [15:0] j1, input logic [15:0] j2);
    mFrame  = {j2, j1};
    mShifts = 0;
    mOvr    = 1'b0;
    mArmed  = 1;
    mLink   = 1'b1;
  endtask

  task automatic modelShift();
    if (mArmed) begin
      if (mShifts < 32) begin
        mShifts++;
        if (mShifts == 32) fdTotal++;
      end else begin
        mOvr = 1'b1;
      end
    end
  endtask

  task automatic doLoad(input string name, input logic [15:0] j1, input logic [15:0] j2);
    joystick1 = j1;
    joystick2 = j2;
    applyStimulus(1'b0, JOY_CLK);
    modelLoad(j1, j2);
    idle(6);
    applyStimulus(1'b1, JOY_CLK);
    pushExpect(name, cyc + 5, 0);
    idle(6);
  endtask

  task automatic doShift(input string name);
    applyStimulus(JOY_LOAD, 1'b1);
    modelShift();
    pushExpect(name, cyc + 5, 0);
    idle(6);
    applyStimulus(JOY_LOAD, 1'b0);
    idle(5);
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lastLoad;
    int start;
    int guard;

    reset_n   = 1'b0;
    JOY_CLK   = 1'b0;
    JOY_LOAD  = 1'b1;
    joystick1 = '0;
    joystick2 = '0;
    modelReset();
    idle(3);
    pushExpect("reset_state", cyc, 0);
    idle(3);
    reset_n = 1'b1;
    idle(4);

    // A host clock before any load must not advance anything.
    doShift("noload_shift");

    // Output latency: raw edge to JOY_DATA change is exactly 4 cycles.
    doLoad("lat_load", 16'h0002, 16'h0000);
    applyStimulus(1'b1, 1'b1);
    pushExpect("lat_cycle3", cyc + 3, 1);
    modelShift();
    pushExpect("lat_cycle4", cyc + 4, 1);
    pushExpect("lat_state", cyc + 5, 0);
    idle(6);
    applyStimulus(1'b1, 1'b0);
    idle(5);

    // Full frame with only the first and last bits pressed.
    doLoad("frame_load", 16'h0001, 16'h8000);
    for (int k = 1; k <= 32; k++) doShift($sformatf("frame_shift%0d", k));

    // Joystick change mid-frame must not leak into the loaded frame.
    doLoad("midchg_load", 16'h0000, 16'h0000);
    for (int k = 1; k <= 3; k++) doShift($sformatf("midchg_shift%0d", k));
    @(negedge clk);
    joystick1 = 16'hFFFF;
    for (int k = 4; k <= 32; k++) doShift($sformatf("midchg_shift%0d", k));

    // Overrun after 33 edges, cleared by the next load.
    doLoad("ovr_load", 16'hA5C3, 16'h3C5A);
    for (int k = 1; k <= 33; k++) doShift($sformatf("ovr_shift%0d", k));
    doLoad("ovr_clear", 16'h5A3C, 16'hC3A5);

    // Clock edge while load is held low: load wins.
    joystick1 = 16'h0001;
    joystick2 = 16'h0000;
    applyStimulus(1'b0, 1'b0);
    modelLoad(16'h0001, 16'h0000);
    idle(4);
    applyStimulus(1'b0, 1'b1);
    pushExpect("hold_clk", cyc + 5, 0);
    idle(6);
    applyStimulus(1'b0, 1'b0);
    idle(3);
    applyStimulus(1'b1, 1'b0);
    pushExpect("hold_release", cyc + 5, 0);
    idle(6);

    // Load falling and clock rising in the same cycle: still no shift.
    joystick1 = 16'h0002;
    applyStimulus(1'b0, 1'b1);
    modelLoad(16'h0002, 16'h0000);
    pushExpect("simul_edge", cyc + 5, 0);
    idle(6);
    applyStimulus(1'b1, 1'b1);
    pushExpect("simul_release", cyc + 5, 0);
    idle(6);
    applyStimulus(1'b1, 1'b0);
    idle(5);

    // Reset mid-frame abandons it; later clocks without a load do nothing.
    doLoad("rstmid_load", 16'h1234, 16'h5678);
    for (int k = 1; k <= 10; k++) doShift($sformatf("rstmid_shift%0d", k));
    @(negedge clk);
    reset_n = 1'b0;
    modelReset();
    pushExpect("rstmid_during", cyc + 1, 0);
    idle(3);
    reset_n = 1'b1;
    idle(3);
    for (int k = 1; k <= 5; k++) doShift($sformatf("postrst_shift%0d", k));

    // Periodic loads keep the link up; it drops TIMEOUT cycles after the last.
    lastLoad = 0;
    for (int i = 0; i < 5; i++) begin
      start = cyc;
      joystick1 = 16'h0001;
      joystick2 = 16'h0000;
      applyStimulus(1'b0, 1'b0);
      modelLoad(16'h0001, 16'h0000);
      lastLoad = cyc;
      idle(6);
      linkWatch = 1'b1;
      applyStimulus(1'b1, 1'b0);
      pushExpect($sformatf("link_load%0d", i), cyc + 5, 0);
      while (cyc < start + 1000) @(negedge clk);
    end
    pushExpect("link_before_expiry", lastLoad + 48002, 0);
    mLink = 1'b0;
    pushExpect("link_after_expiry", lastLoad + 48003, 0);
    while (cyc < lastLoad + 48002) @(negedge clk);
    linkWatch = 1'b0;
    checkOutput("link_held", 32'(linkDrop), 32'd0);

    guard = 0;
    while (sbQ.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("scoreboard_drain", 32'(sbQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
